// File: rtl/clk_div_bank.sv
// Bank of independent programmable divider / clock-enable channels.
// Divide value and mode are shadowed and only take effect at a period boundary.
module clk_div_bank #(
  parameter int unsigned  NUM_CH   = 4,
  parameter int unsigned  CNT_W    = 24,
  parameter int unsigned  DIV_INIT = 20,
  parameter bit           INVERT   = 1'b1,
  localparam int unsigned CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic              cfg_mode,
  input  logic [NUM_CH-1:0] en,
  input  logic              sync,
  output logic [NUM_CH-1:0] out,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] cfg_pending
);

  logic [CNT_W-1:0]  r_cnt   [NUM_CH];
  logic [CNT_W-1:0]  r_div_a [NUM_CH];
  logic [CNT_W-1:0]  r_div_s [NUM_CH];
  logic [NUM_CH-1:0] r_mode_a;
  logic [NUM_CH-1:0] r_mode_s;
  logic [NUM_CH-1:0] r_pend;
  logic [NUM_CH-1:0] r_raw;
  logic [NUM_CH-1:0] r_tick;

  logic [NUM_CH-1:0] w_term;
  logic [NUM_CH-1:0] w_apply;
  logic [NUM_CH-1:0] w_wr;

  // Terminal count, apply point and per-channel write select.
  // Out-of-range cfg_ch never matches any channel index, so such writes drop.
  always_comb begin
    w_term  = '0;
    w_apply = '0;
    w_wr    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_term[i]  = en[i] && (r_cnt[i] == r_div_a[i]);
      w_apply[i] = w_term[i] || !en[i] || sync;
      w_wr[i]    = cfg_we && (cfg_ch == CH_W'(i));
    end
  end

  // Counter, tick strobe and raw waveform bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_cnt[i] <= '0;
      end
      r_raw  <= '0;
      r_tick <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (sync || !en[i]) begin
          r_cnt[i]  <= '0;
          r_raw[i]  <= 1'b0;
          r_tick[i] <= 1'b0;
        end else if (w_term[i]) begin
          r_cnt[i]  <= '0;
          r_tick[i] <= 1'b1;
          r_raw[i]  <= r_mode_a[i] | ~r_raw[i];
        end else begin
          r_cnt[i]  <= r_cnt[i] + CNT_W'(1);
          r_tick[i] <= 1'b0;
          r_raw[i]  <= r_raw[i] & ~r_mode_a[i];
        end
      end
    end
  end

  // Shadow / active configuration; a write landing on an apply point bypasses the shadow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_div_a[i] <= CNT_W'(DIV_INIT);
        r_div_s[i] <= CNT_W'(DIV_INIT);
      end
      r_mode_a <= '0;
      r_mode_s <= '0;
      r_pend   <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_wr[i]) begin
          r_div_s[i]  <= cfg_div;
          r_mode_s[i] <= cfg_mode;
          if (w_apply[i]) begin
            r_div_a[i]  <= cfg_div;
            r_mode_a[i] <= cfg_mode;
            r_pend[i]   <= 1'b0;
          end else begin
            r_pend[i]   <= 1'b1;
          end
        end else if (w_apply[i] && r_pend[i]) begin
          r_div_a[i]  <= r_div_s[i];
          r_mode_a[i] <= r_mode_s[i];
          r_pend[i]   <= 1'b0;
        end
      end
    end
  end

  assign out         = r_raw ^ {NUM_CH{INVERT}};
  assign tick        = r_tick;
  assign cfg_pending = r_pend;

endmodule
